word_deserializer: RTL and testbench
====================================

# word_deserializer

Serial-to-parallel receiver for the 16-bit datapath. It accepts a bit stream one bit per clock, LSB first, and assembles each 16 bits into a word. It presents each completed word on a valid/ready output buffered by a single holding register. It is the receiving end of the bit-serial link that carries 16-bit words between the gate-level word units (Or16, And16, etc.) and off-chip peripherals.

## Interface
- WIDTH, 16, word width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- sin_valid  input  1  sin_bit is valid this cycle
- sin_bit  input  1  serial data bit
- sin_start  input  1  qualified by sin_valid; marks this bit as bit 0 of a new word
- out  output  WIDTH  assembled word; bit 0 = first bit received
- out_valid  output  1  out holds an unconsumed word
- out_ready  input  1  consumer accepts out when out_valid && out_ready
- overrun  output  1  one-cycle pulse when a completed word is dropped
- busy  output  1  a partial word is in the shift register (bit count != 0)

## Operation
- Registers:
  - shift register sreg[WIDTH-1:0]
  - bit counter cnt, width clog2(WIDTH)
  - holding register out, with its flag out_valid
- Reset values: sreg=0, cnt=0, out=0, out_valid=0, overrun=0, busy=0.
- Receive state machine, with state derived from cnt:
  - IDLE (cnt==0): waits for sin_valid.
  - SHIFT (cnt in 1..WIDTH-1): collecting bits.
- Each cycle with sin_valid=1:
  - The bit is written to sreg[cnt] (LSB first).
  - cnt increments.
  - When cnt==WIDTH-1, the word is complete and cnt wraps to 0.
- sin_start=1 with sin_valid=1:
  - Discards any partial word.
  - Stores sin_bit as bit 0 and sets cnt=1.
  - For WIDTH=1 this would be immediate completion; that case is excluded by the legal parameter range.
- sin_valid=0: no change to sreg or cnt. Gaps of any length are allowed mid-word.
- sin_start with sin_valid=0 is ignored.
- Word completion sets complete=1 for that edge.
  - The completed word, including the final bit, is {sin_bit, sreg[WIDTH-2:0]}.
- Holding register update at each edge, in priority order:
  1. If complete and (!out_valid or out_ready): load out with the completed word, set out_valid=1.
  2. Else if complete and out_valid and !out_ready: drop the completed word; out and out_valid are unchanged; overrun=1 for the next cycle.
  3. Else if out_valid and out_ready: out_valid=0. out keeps its last value.
- Simultaneous completion and consumption: the old word is accepted, the new word is loaded, out_valid stays 1, and there is no overrun.
- Dropping a word does not affect reception of the next word. cnt has already wrapped to 0.
- busy = (cnt != 0).

## Timing
- Latency: the final bit is sampled at edge N; out and out_valid are updated after edge N. The consumer sees the word in cycle N+1.
- Throughput: one word per WIDTH valid input cycles. With out_ready held at 1, there is never an overrun.
- out is stable while out_valid=1 and out_ready=0.
- overrun is registered and asserted for exactly one cycle per dropped word.
- Reset is asynchronous on assertion and synchronous in effect on release. The first bit is sampled at the first rising edge after reset deasserts.
- Reset mid-word or with out_valid=1: all state is discarded; outputs return to their reset values immediately.
- There is no combinational path from any input to any output.

## Structure
- Shared package:
  - default WIDTH (16)
  - the counter width function clog2
- The same package is reused by the matching serializer.
- One sub-module is natural: word_hold_reg, the holding register with its valid/ready and overrun logic.
- The shift register and counter stay in the top module.
- No other hierarchy.

## Test plan
- **Basic word:** after reset, send 0xA5C3 LSB first, 16 consecutive valid cycles, out_ready=1 -> out_valid=1 one cycle after the 16th bit, out=0xA5C3, overrun never asserted.
- **Gapped input:** send 0x0001 with sin_valid=0 for 3 cycles between every bit -> out=0x0001; busy=1 from the first bit until completion.
- **Resync:** send 5 bits, then assert sin_start with the word 0xFFFF -> out=0xFFFF, exactly one word delivered.
- **Backpressure/overrun:** out_ready=0, send 0x1234 then 0x5678 back to back -> out=0x1234 held, out_valid=1, one overrun pulse at the 0x5678 completion. Then raise out_ready -> 0x1234 accepted, out_valid=0.
- **Simultaneous accept and complete:** hold 0x1111, then raise out_ready in the same cycle the last bit of 0x2222 arrives -> out=0x2222, out_valid stays 1, no overrun.
- **Reset mid-operation:** assert reset after 8 bits with a word held -> out=0, out_valid=0, busy=0 immediately. A following word 0xBEEF is received correctly.

Source files
------------

// File: rtl/word_deserializer_pkg.sv
// Shared definitions for the 16-bit serial link (deserializer and matching serializer).
package word_deserializer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

    // Smallest r with 2**r >= value; sizes the bit counter.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/word_hold_reg.sv
// Single-entry output buffer for completed words: valid/ready handshake plus overrun pulse.
module word_hold_reg
    import word_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             complete,
    input  logic [WIDTH-1:0] word,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] out_nxt;
    logic             out_valid_nxt;
    logic             overrun_nxt;

    // A new word wins over consumption; a word arriving into a full, stalled buffer is dropped.
    always_comb begin
        out_nxt       = out;
        out_valid_nxt = out_valid;
        overrun_nxt   = 1'b0;
        if (complete && (!out_valid || out_ready)) begin
            out_nxt       = word;
            out_valid_nxt = 1'b1;
        end else if (complete) begin
            overrun_nxt   = 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out       <= out_nxt;
            out_valid <= out_valid_nxt;
            overrun   <= overrun_nxt;
        end
    end

endmodule

// File: rtl/word_deserializer.sv
// Serial-to-parallel receiver: LSB-first bit stream in, WIDTH-bit words out via a holding register.
module word_deserializer
    import word_deserializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin_valid,
    input  logic             sin_bit,
    input  logic             sin_start,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned      CNT_W = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             complete;
    logic [WIDTH-1:0] word;
    rx_state_e        state;

    // Bit counter doubles as the receive state; busy is registered from the next count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else begin
            sreg <= sreg_nxt;
            cnt  <= cnt_nxt;
            busy <= (cnt_nxt != '0);
        end
    end

    always_comb begin
        state    = (cnt == '0) ? RX_IDLE : RX_SHIFT;
        sreg_nxt = sreg;
        cnt_nxt  = cnt;
        complete = 1'b0;
        word     = {sin_bit, sreg[WIDTH-2:0]};
        if (sin_valid) begin
            if (sin_start) begin
                // Resync: drop the partial word and restart at bit 0.
                sreg_nxt = {{(WIDTH-1){1'b0}}, sin_bit};
                cnt_nxt  = ONE;
            end else begin
                case (state)
                    RX_IDLE: begin
                        sreg_nxt = {{(WIDTH-1){1'b0}}, sin_bit};
                        cnt_nxt  = ONE;
                    end
                    RX_SHIFT: begin
                        sreg_nxt[cnt] = sin_bit;
                        if (cnt == LAST) begin
                            complete = 1'b1;
                            cnt_nxt  = '0;
                        end else begin
                            cnt_nxt  = cnt + ONE;
                        end
                    end
                    default: begin
                        cnt_nxt = '0;
                    end
                endcase
            end
        end
    end

    word_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .complete  (complete),
        .word      (word),
        .out_ready (out_ready),
        .out       (out),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_word_deserializer.sv
// Bench for word_deserializer: directed scenarios plus random traffic against a queue-based model.
module tb_word_deserializer;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         sin_valid;
    logic         sin_bit;
    logic         sin_start;
    logic         out_ready;
    logic [W-1:0] out;
    logic         out_valid;
    logic         overrun;
    logic         busy;

    int total = 0;
    int bad = 0;
    int ovr_seen = 0;
    int words_seen = 0;

    // Model state: bits of the word in progress, and the single output slot.
    bit           q[$];
    logic [W-1:0] m_out;
    logic         m_valid;
    logic         m_ovr;
    logic         m_busy;

    always #5 clk = ~clk;

    word_deserializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .sin_valid (sin_valid),
        .sin_bit   (sin_bit),
        .sin_start (sin_start),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    // Reference: collect bits in a queue; a full queue of W bits is a finished word.
    always @(posedge clk or posedge reset) begin
        logic         done;
        logic [W-1:0] w;
        if (reset) begin
            q.delete();
            m_out   <= '0;
            m_valid <= 1'b0;
            m_ovr   <= 1'b0;
            m_busy  <= 1'b0;
        end else begin
            done = 1'b0;
            w    = '0;
            if (sin_valid) begin
                if (sin_start) q.delete();
                q.push_back(sin_bit);
                if (q.size() == int'(W)) begin
                    for (int i = 0; i < int'(W); i++) w[i] = q[i];
                    done = 1'b1;
                    q.delete();
                end
            end
            m_ovr <= 1'b0;
            if (done && (!m_valid || out_ready)) begin
                m_out   <= w;
                m_valid <= 1'b1;
            end else if (done) begin
                m_ovr   <= 1'b1;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
            m_busy <= (q.size() != 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("out", 32'(out), 32'(m_out));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("busy", 32'(busy), 32'(m_busy));
        if (overrun === 1'b1) ovr_seen++;
        if (out_valid === 1'b1) words_seen++;
    endtask

    // One clock: check outputs on the falling edge, then drive the next inputs.
    task automatic cyc(input logic v, input logic b, input logic s, input logic r);
        @(negedge clk);
        compare_all();
        sin_valid = v;
        sin_bit   = b;
        sin_start = s;
        out_ready = r;
    endtask

    task automatic send(input logic [W-1:0] w, input logic start, input int gap,
                        input logic r, input logic r_last);
        for (int i = 0; i < int'(W); i++) begin
            if (i != 0) begin
                for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, r);
            end
            cyc(1'b1, w[i], (i == 0) ? start : 1'b0, (i == int'(W) - 1) ? r_last : r);
        end
    endtask

    initial begin
        reset = 1'b1;
        sin_valid = 1'b0;
        sin_bit = 1'b0;
        sin_start = 1'b0;
        out_ready = 1'b0;

        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;

        // Basic word
        ovr_seen = 0;
        send(16'hA5C3, 1'b0, 0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_out", 32'(out), 32'hA5C3);
        chk("basic_valid", 32'(out_valid), 32'h1);
        chk("basic_model", 32'(m_out), 32'hA5C3);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("basic_no_ovr", 32'(ovr_seen), 32'h0);

        // Gapped input
        send(16'h0001, 1'b0, 3, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap_out", 32'(out), 32'h0001);
        chk("gap_busy_done", 32'(busy), 32'h0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Resync: partial word abandoned by sin_start
        words_seen = 0;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        chk("resync_busy", 32'(busy), 32'h1);
        send(16'hFFFF, 1'b1, 0, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("resync_out", 32'(out), 32'hFFFF);
        chk("resync_count", 32'(words_seen), 32'h1);

        // Backpressure and overrun
        ovr_seen = 0;
        send(16'h1234, 1'b0, 0, 1'b0, 1'b0);
        send(16'h5678, 1'b0, 0, 1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_out", 32'(out), 32'h1234);
        chk("bp_valid", 32'(out_valid), 32'h1);
        chk("bp_ovr", 32'(ovr_seen), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_drained", 32'(out_valid), 32'h0);
        chk("bp_out_kept", 32'(out), 32'h1234);

        // Simultaneous accept and complete
        send(16'h1111, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sim_hold", 32'(out), 32'h1111);
        ovr_seen = 0;
        send(16'h2222, 1'b0, 0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sim_out", 32'(out), 32'h2222);
        chk("sim_valid", 32'(out_valid), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sim_no_ovr", 32'(ovr_seen), 32'h0);

        // Reset mid-word with a word held
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("mrst_out", 32'(out), 32'h0);
        chk("mrst_valid", 32'(out_valid), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        send(16'hBEEF, 1'b0, 0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("mrst_beef", 32'(out), 32'hBEEF);
        chk("mrst_beef_valid", 32'(out_valid), 32'h1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 99) < 60));
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
